// File: rtl/ddr_slot_fifo.sv
// Bundle FIFO between the DDR command execute stage and the PHY adapter.
// Registered output stage plus occupancy, high-water and underrun statistics.
module ddr_slot_fifo #(
    parameter int SLOTS    = 4,
    parameter int SLOT_W   = 64,
    parameter int WDATA_W  = 512,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SLOTS*SLOT_W-1:0] in_slots,
    input  logic [SLOTS-1:0]        in_slot_vld,
    input  logic [WDATA_W-1:0]      in_wdata,
    input  logic                    out_ready,
    output logic [SLOTS*SLOT_W-1:0] out_slots,
    output logic [SLOTS-1:0]        out_slot_vld,
    output logic [WDATA_W-1:0]      out_wdata,
    input  logic                    flush,
    input  logic                    seq_end,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  hwm,
    output logic [15:0]             underrun_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int SW = SLOTS * SLOT_W;
    localparam int EW = WDATA_W + SLOTS + SW;
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L   = LW'(AF_LEVEL);

    // Handshakes: a bundle moves on in_valid & in_ready (in_ready never looks at
    // in_valid); the output side consumes whenever out_ready is high, taking a
    // NOP bundle if the queue is empty.

    logic [1:0]          rst_sync_q, rst_sync_d;
    logic [LW-1:0]       level_q, level_d;
    logic [LW-1:0]       hwm_q, hwm_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [15:0]         underrun_q, underrun_d;
    logic                armed_q, armed_d;
    logic [SW-1:0]       out_slots_q, out_slots_d;
    logic [SLOTS-1:0]    out_slot_vld_q, out_slot_vld_d;
    logic [WDATA_W-1:0]  out_wdata_q, out_wdata_d;

    logic [EW-1:0]       mem [DEPTH];
    logic [EW-1:0]       rd_entry;
    logic                push;
    logic                pop;
    logic                empty;

    // Release is delayed two edges so the first push never races reset removal.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    assign empty    = (level_q == '0);
    assign in_ready = rst_sync_q[1] && (level_q != FULL_L);
    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_ready && !empty && !flush;
    assign rd_entry = mem[rd_ptr_q];

    always_comb begin
        level_d        = level_q;
        hwm_d          = hwm_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        underrun_d     = underrun_q;
        armed_d        = armed_q;
        out_slots_d    = out_slots_q;
        out_slot_vld_d = out_slot_vld_q;
        out_wdata_d    = out_wdata_q;

        if (flush) begin
            level_d        = '0;
            hwm_d          = '0;
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            underrun_d     = '0;
            armed_d        = 1'b0;
            out_slots_d    = '0;
            out_slot_vld_d = '0;
            out_wdata_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end

            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase

            if (level_d > hwm_q) begin
                hwm_d = level_d;
            end

            if (out_ready) begin
                if (pop) begin
                    out_slots_d    = rd_entry[SW-1:0];
                    out_slot_vld_d = rd_entry[SW +: SLOTS];
                    out_wdata_d    = rd_entry[EW-1 -: WDATA_W];
                end else begin
                    out_slots_d    = '0;
                    out_slot_vld_d = '0;
                    out_wdata_d    = '0;
                end
            end

            // A push in the same cycle as seq_end keeps the program armed.
            if (push) begin
                armed_d = 1'b1;
            end else if (seq_end) begin
                armed_d = 1'b0;
            end

            if (armed_q && out_ready && empty && (underrun_q != 16'hFFFF)) begin
                underrun_d = underrun_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q     <= '0;
            level_q        <= '0;
            hwm_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            underrun_q     <= '0;
            armed_q        <= 1'b0;
            out_slots_q    <= '0;
            out_slot_vld_q <= '0;
            out_wdata_q    <= '0;
        end else begin
            rst_sync_q     <= rst_sync_d;
            level_q        <= level_d;
            hwm_q          <= hwm_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            underrun_q     <= underrun_d;
            armed_q        <= armed_d;
            out_slots_q    <= out_slots_d;
            out_slot_vld_q <= out_slot_vld_d;
            out_wdata_q    <= out_wdata_d;
        end
    end

    // Storage holds no control state, so it is left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_wdata, in_slot_vld, in_slots};
        end
    end

    assign out_slots    = out_slots_q;
    assign out_slot_vld = out_slot_vld_q;
    assign out_wdata    = out_wdata_q;
    assign level        = level_q;
    assign almost_full  = (level_q >= AF_L);
    assign hwm          = hwm_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: doc/ddr_slot_fifo.md
DDR_SLOT_FIFO -- requirements
Module: ddr_slot_fifo

Interface
REQ-001 Parameter SLOTS, default 4: DDR command slots per fabric cycle (1..8).
REQ-002 Parameter SLOT_W, default 64: packed width of one slot's command fields (cmd flags, rank, bg, bank, row, col, ch).
REQ-003 Parameter WDATA_W, default 512: write-data width per bundle.
REQ-004 Parameter DEPTH, default 16: bundle entries; power of two, 4..256.
REQ-005 Parameter AF_LEVEL, default DEPTH-2: almost-full threshold.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 in_valid  in  1  execute stage presents a bundle.
REQ-009 in_ready  out  1  FIFO can accept a bundle this cycle.
REQ-010 in_slots  in  SLOTS*SLOT_W  slot payloads; slot 0 in LSBs.
REQ-011 in_slot_vld  in  SLOTS  per-slot command valid; 0 = NOP in that slot.
REQ-012 in_wdata  in  WDATA_W  write data for the bundle.
REQ-013 out_ready  in  1  PHY adapter consumes the output bundle this cycle.
REQ-014 out_slots  out  SLOTS*SLOT_W  registered slot payloads.
REQ-015 out_slot_vld  out  SLOTS  registered per-slot valid.
REQ-016 out_wdata  out  WDATA_W  registered write data.
REQ-017 flush  in  1  synchronous clear of queue and statistics.
REQ-018 seq_end  in  1  one-cycle pulse: program end, disarms underrun counting.
REQ-019 level  out  clog2(DEPTH)+1  current occupancy.
REQ-020 almost_full  out  1  level >= AF_LEVEL.
REQ-021 hwm  out  clog2(DEPTH)+1  maximum occupancy since reset/flush.
REQ-022 underrun_cnt  out  16  starved output cycles while armed.

Function
REQ-023 in_ready = (level != DEPTH), combinational from registered level; push = in_valid & in_ready.
REQ-024 Pop occurs when out_ready=1 and level!=0; popped entry loads out_* registers that edge.
REQ-025 When out_ready=1 and level==0, out_slot_vld loads all zeros (NOP bundle), out_slots/out_wdata load zero.
REQ-026 When out_ready=0, out_* hold their values; no pop.
REQ-027 Latency: bundle pushed in cycle N with empty FIFO and out_ready high appears on out_* in cycle N+2; no fall-through.
REQ-028 Push and pop in the same cycle: level unchanged; allowed at any non-full level; at full, push refused (in_ready=0).
REQ-029 Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-030 Bundle order preserved; slot order within a bundle preserved; entries with in_slot_vld=0 are still queued.
REQ-031 hwm updates to level_next when level_next > hwm.
REQ-032 Armed flag set by any push; cleared by seq_end or flush; push and seq_end together leave armed set.
REQ-033 underrun_cnt increments when armed & out_ready & level==0; saturates at 16'hFFFF.
REQ-034 flush: level, pointers, hwm, underrun_cnt, armed go to 0 next edge; out_slot_vld loads 0; concurrent push dropped.
REQ-035 almost_full and level are registered-state derived, no combinational path from in_valid.

Reset
REQ-036 rst_n low: level=0, pointers=0, hwm=0, underrun_cnt=0, armed=0, out_slot_vld=0, out_slots=0, out_wdata=0, immediately, asynchronously.
REQ-037 rst_n release synchronised internally (2-flop deassert); first push accepted no earlier than 2nd edge after release.
REQ-038 Reset mid-operation discards all queued bundles; no partial bundle emitted.
REQ-039 Storage array need not be reset.

Verification
REQ-040 Defaults, out_ready=1, push one bundle (slot_vld=4'b0101) at N -> out_slot_vld=4'b0101 at N+2, 4'b0000 at N+3.
REQ-041 out_ready=0, push 16 bundles -> level=16, in_ready=0, almost_full from level 14, hwm=16; 17th bundle not accepted.
REQ-042 Full, in_valid=1, out_ready=1 for 20 cycles -> exactly one push per pop after first pop, order intact, level stays 15/16, no loss.
REQ-043 Push 1 bundle then idle 10 cycles with out_ready=1 -> underrun_cnt=9; seq_end pulse then 5 idle -> still 9; flush -> 0.
REQ-044 Push 8 bundles, assert rst_n low mid-drain -> out_slot_vld=0 same cycle, level=0; after release no stale bundle emerges.
REQ-045 SLOTS=2, DEPTH=4 build: push 6 with random out_ready -> pointer wrap, data order and level match scoreboard.
